// File: rtl/riscv_pkg.sv
`default_nettype none
// ============================================================================
// Package  : riscv_pkg
// Purpose  : Shared constants and types for the RISC-V fetch stage.
//            XLEN        - default datapath / address width
//            NOP_INSTR   - canonical NOP (addi x0, x0, 0)
//            fetch_state_t - fetch FSM state encoding
// Revision : 1.0 - initial release
// ============================================================================
package riscv_pkg;

  localparam int unsigned XLEN = 32;
  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

  typedef enum logic [2:0] {
    BOOT = 3'd0,  // one idle cycle after reset release
    REQ  = 3'd1,  // request outstanding on the instruction port
    WAIT = 3'd2,  // granted, waiting for read data
    HOLD = 3'd3,  // instruction presented to decode
    TRAP = 3'd4   // misaligned target taken; only reset leaves
  } fetch_state_t;

endpackage : riscv_pkg
`default_nettype wire

// File: rtl/pc_next_logic.sv
`default_nettype none
// ============================================================================
// Module   : pc_next_logic
// Purpose  : Combinational next-PC selection for the fetch stage.
// Ports    : pc          in   XLEN  current PC
//            pcsrc       in   1     1: take pc_target, 0: sequential
//            pc_target   in   XLEN  branch / jump target
//            pc_plus4    out  XLEN  pc + 4 (modulo 2^XLEN)
//            pc_next     out  XLEN  selected next PC
//            misaligned  out  1     selected next PC not 4-byte aligned
// Revision : 1.0 - initial release
// ============================================================================
module pc_next_logic #(
  parameter int unsigned XLEN = riscv_pkg::XLEN
) (
  input  logic [XLEN-1:0] pc,
  input  logic            pcsrc,
  input  logic [XLEN-1:0] pc_target,
  output logic [XLEN-1:0] pc_plus4,
  output logic [XLEN-1:0] pc_next,
  output logic            misaligned
);

  // Plain XLEN-bit add: the carry out is dropped, so 0xFFFFFFFC wraps to 0.
  assign pc_plus4 = pc + XLEN'(4);

  always_comb begin
    pc_next    = pcsrc ? pc_target : pc_plus4;
    misaligned = (pc_next[1:0] != 2'b00);
  end

endmodule : pc_next_logic
`default_nettype wire

// File: rtl/pc_fetch_stage.sv
`default_nettype none
// ============================================================================
// Module   : pc_fetch_stage
// Purpose  : Program counter and instruction fetch stage. Holds the
//            architectural PC, fetches one instruction at a time over a
//            req/gnt/rvalid port and presents it to decode until consumed.
// Ports    : clk          in   1     clock, rising edge
//            rst_n        in   1     asynchronous active-low reset
//            PCsrc        in   1     1: next PC = PCTarget, 0: PC + 4
//            PCTarget     in   XLEN  branch / jump target
//            stall        in   1     decode cannot accept held instruction
//            imem_req     out  1     fetch request valid
//            imem_addr    out  XLEN  fetch address (= pc_out)
//            imem_gnt     in   1     request accepted this cycle
//            imem_rvalid  in   1     imem_rdata valid this cycle
//            imem_rdata   in   32    fetched instruction word
//            instr_valid  out  1     instr holds a fetched instruction
//            instr        out  32    instruction presented to decode
//            pc_out       out  XLEN  PC of current / held instruction
//            pc_plus4     out  XLEN  pc_out + 4 (link value)
//            misaligned   out  1     sticky misaligned-target flag
// Revision : 1.0 - initial release
// ============================================================================
module pc_fetch_stage #(
  parameter int unsigned        XLEN     = riscv_pkg::XLEN,
  parameter logic [XLEN-1:0]    RESET_PC = '0
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            PCsrc,
  input  logic [XLEN-1:0] PCTarget,
  input  logic            stall,
  output logic            imem_req,
  output logic [XLEN-1:0] imem_addr,
  input  logic            imem_gnt,
  input  logic            imem_rvalid,
  input  logic [31:0]     imem_rdata,
  output logic            instr_valid,
  output logic [31:0]     instr,
  output logic [XLEN-1:0] pc_out,
  output logic [XLEN-1:0] pc_plus4,
  output logic            misaligned
);

  import riscv_pkg::*;

  fetch_state_t    state_q, state_d;
  logic [XLEN-1:0] pc_q, pc_d;
  logic [31:0]     instr_q, instr_d;

  logic [XLEN-1:0] nl_pc_next;
  logic            nl_misaligned;

  pc_next_logic #(
    .XLEN (XLEN)
  ) u_pc_next_logic (
    .pc         (pc_q),
    .pcsrc      (PCsrc),
    .pc_target  (PCTarget),
    .pc_plus4   (pc_plus4),
    .pc_next    (nl_pc_next),
    .misaligned (nl_misaligned)
  );

  // Next-state logic. Responses are only looked at in WAIT, so a stale rvalid
  // left over from before a reset is dropped. The redirect inputs are only
  // looked at when the held instruction is actually consumed.
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    instr_d = instr_q;
    case (state_q)
      BOOT: state_d = REQ;
      REQ: begin
        // A same-cycle rvalid is ignored; the grant alone moves us on.
        if (imem_gnt) state_d = WAIT;
      end
      WAIT: begin
        if (imem_rvalid) begin
          instr_d = imem_rdata;
          state_d = HOLD;
        end
      end
      HOLD: begin
        if (!stall) begin
          // The offending target is kept in pc so it is visible in TRAP.
          pc_d    = nl_pc_next;
          state_d = nl_misaligned ? TRAP : REQ;
        end
      end
      TRAP: state_d = TRAP;
      default: state_d = BOOT;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= BOOT;
      pc_q    <= RESET_PC;
      instr_q <= NOP_INSTR;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      instr_q <= instr_d;
    end
  end

  // Control outputs decode directly from the registered state.
  assign imem_req    = (state_q == REQ);
  assign instr_valid = (state_q == HOLD);
  assign misaligned  = (state_q == TRAP);
  assign imem_addr   = pc_q;
  assign pc_out      = pc_q;
  assign instr       = instr_q;

endmodule : pc_fetch_stage
`default_nettype wire
